// File: rtl/fetch_buf_pkg.sv
// Shared constants for the instruction fetch buffer: default datapath widths
// and the sequential PC increment.
package fetch_buf_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;
  localparam int unsigned PC_INCR         = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO holding prefetched {instr, pc} entries.
// Pointers wrap naturally (DEPTH is a power of two). flush empties the queue
// and overrides push/pop in the same cycle. A push into a full queue is
// accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CW'(DEPTH));
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop && head_valid;
  assign do_push    = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while head_valid is set.
  always_ff @(posedge cpu_clk) begin
    if (!flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_buf.sv
// Instruction prefetch buffer between imem_ctrl and dec.
// Issues up to MAX_OUTST pipelined imem requests, queues returned
// instructions in a DEPTH-entry FIFO and drops stale responses after a
// redirect. Optional feature macro: KRV_FETCH_BYPASS_EN (zero-latency path
// from imem_rdata to DEC when the queue is empty).
//
// Handshakes: imem request transfers when imem_req && imem_gnt (imem_addr is
// held until granted); a response is one cycle of imem_rvalid, in request
// order, never stalled; a queue entry transfers to DEC when
// if_valid && dec_ready.
module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH       = 4,
  parameter int MAX_OUTST   = 2
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] instr_dec,
  output logic [ADDR_WIDTH-1:0]  pc_dec,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_dec,
  input  logic                   dec_ready,
  output logic                   pc_misaligned,
  output logic [ADDR_WIDTH-1:0]  fault_pc
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + OW + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCR);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  resp_pc;
  logic [OW-1:0]          outst;
  logic [OW-1:0]          outst_next;
  logic [OW-1:0]          discard;
  logic                   run;
  logic                   fire;
  logic                   resp_live;
  logic                   bypass;
  logic                   push;
  logic                   fifo_pop;
  logic [SW-1:0]          credit_used;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_valid;
  logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head_data;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0]  head_pc;

  assign head_instr = head_data[INSTR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign head_pc    = head_data[ADDR_WIDTH-1:0];
  assign imem_addr  = fetch_pc;

  // Credit check, outstanding tracking and push/pop qualification.
  always_comb begin
    credit_used = SW'(fifo_count) + SW'(outst) - SW'(discard);
    imem_req    = run && !redirect && !halt && !pc_misaligned &&
                  (outst < OW'(MAX_OUTST)) && (credit_used < SW'(DEPTH));
    fire        = imem_req && imem_gnt;
    outst_next  = outst;
    if (fire && !imem_rvalid)      outst_next = outst + OW'(1);
    else if (!fire && imem_rvalid) outst_next = outst - OW'(1);
    resp_live   = imem_rvalid && (discard == '0) && !redirect;
`ifdef KRV_FETCH_BYPASS_EN
    bypass      = resp_live && !fifo_valid;
`else
    bypass      = 1'b0;
`endif
    push        = resp_live && !(bypass && dec_ready);
    fifo_pop    = fifo_valid && dec_ready && !redirect;
  end

  // DEC-facing outputs; an empty queue shows the next expected response PC.
  always_comb begin
    if_valid  = fifo_valid;
    instr_dec = fifo_valid ? head_instr : '0;
    pc_dec    = fifo_valid ? head_pc : resp_pc;
`ifdef KRV_FETCH_BYPASS_EN
    if (bypass) begin
      if_valid  = 1'b1;
      instr_dec = imem_rdata;
      pc_dec    = resp_pc;
    end
`endif
    pc_plus4_dec = pc_dec + PC_STEP;
  end

  // Fetch/response PCs, outstanding and discard counters, misalignment flag.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      fetch_pc      <= boot_addr;
      resp_pc       <= boot_addr;
      outst         <= '0;
      discard       <= '0;
      run           <= 1'b0;
      pc_misaligned <= 1'b0;
      fault_pc      <= '0;
    end else begin
      run   <= 1'b1;
      outst <= outst_next;
      if (redirect) begin
        fetch_pc      <= redirect_pc;
        resp_pc       <= redirect_pc;
        discard       <= outst_next;
        pc_misaligned <= (redirect_pc[1:0] != 2'b00);
        fault_pc      <= (redirect_pc[1:0] != 2'b00) ? redirect_pc : '0;
      end else begin
        if (fire)      fetch_pc <= fetch_pc + PC_STEP;
        if (resp_live) resp_pc  <= resp_pc + PC_STEP;
        if (imem_rvalid && (discard != '0)) discard <= discard - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_WIDTH + ADDR_WIDTH)
  ) u_fifo (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .flush      (redirect),
    .push       (push),
    .push_data  ({imem_rdata, resp_pc}),
    .pop        (fifo_pop),
    .head_data  (head_data),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_buf.sv
// Self-checking bench for fetch_buf (DEPTH=4, MAX_OUTST=2). An in-order imem
// responder answers one cycle after grant; each granted request is tagged
// with a redirect epoch so stale responses are known to be dropped.
module tb_fetch_buf;

  localparam int MAX_OUTST = 2;

  typedef struct packed {
    logic [31:0] addr;
    int unsigned tag;
  } pend_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic [31:0] boot_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] instr_dec;
  logic [31:0] pc_dec;
  logic [31:0] pc_plus4_dec;
  logic        dec_ready;
  logic        pc_misaligned;
  logic [31:0] fault_pc;

  logic [63:0] exp_q[$];
  pend_t       pend_q[$];
  int unsigned epoch = 0;
  logic [31:0] exp_fetch_pc;
  logic        m_mis = 1'b0;
  logic        resp_en = 1'b1;
  logic        pop_seen;
  logic [31:0] first_pop_pc;
  int          vectors = 0;
  int          miscompares = 0;

  fetch_buf dut (
    .cpu_clk       (cpu_clk),
    .cpu_rstn      (cpu_rstn),
    .boot_addr     (boot_addr),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .instr_dec     (instr_dec),
    .pc_dec        (pc_dec),
    .pc_plus4_dec  (pc_plus4_dec),
    .dec_ready     (dec_ready),
    .pc_misaligned (pc_misaligned),
    .fault_pc      (fault_pc)
  );

  // Clock and watchdog
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // One clock cycle: sample and check at negedge, update model after posedge,
  // then drive the responder for the next cycle.
  task automatic step();
    logic        exp_req, exp_ifv, hs, rv, live, consumed, redir, have_e;
    logic [31:0] hs_addr, rv_addr, rpc;
    logic [63:0] e;
    int          live_out;
    @(negedge cpu_clk);
    live_out = 0;
    foreach (pend_q[i]) if (pend_q[i].tag == epoch) live_out++;
    redir   = redirect;
    rpc     = redirect_pc;
    exp_req = !redirect && !halt && !m_mis && (pend_q.size() < MAX_OUTST) &&
              ((exp_q.size() + live_out) < 4);
    vectors++;
    if (imem_req !== exp_req) begin
      miscompares++;
      $display("FAIL imem_req @%0t: got %b want %b", $time, imem_req, exp_req);
    end
    hs      = imem_req && imem_gnt;
    hs_addr = imem_addr;
    if (hs) begin
      vectors++;
      if (imem_addr !== exp_fetch_pc) begin
        miscompares++;
        $display("FAIL imem_addr @%0t: got %h want %h", $time, imem_addr, exp_fetch_pc);
      end
    end
    rv      = imem_rvalid;
    rv_addr = (pend_q.size() > 0) ? pend_q[0].addr : 32'h0;
    live    = rv && (pend_q.size() > 0) && (pend_q[0].tag == epoch) && !redirect;
    exp_ifv = (exp_q.size() > 0);
`ifdef KRV_FETCH_BYPASS_EN
    exp_ifv = exp_ifv || live;
`endif
    vectors++;
    if (if_valid !== exp_ifv) begin
      miscompares++;
      $display("FAIL if_valid @%0t: got %b want %b", $time, if_valid, exp_ifv);
    end
    consumed = 1'b0;
    have_e   = 1'b0;
    e        = '0;
    if (if_valid && dec_ready && !redirect) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        have_e = 1'b1;
      end else if (live) begin
        e = {mem_word(rv_addr), rv_addr};
        have_e = 1'b1;
        consumed = 1'b1;
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL pop @%0t: got pop of pc %h want no entry", $time, pc_dec);
      end
      if (have_e) begin
        vectors++;
        if (instr_dec !== e[63:32] || pc_dec !== e[31:0] || pc_plus4_dec !== e[31:0] + 32'd4) begin
          miscompares++;
          $display("FAIL head @%0t: got instr %h pc %h pc4 %h want instr %h pc %h pc4 %h",
                   $time, instr_dec, pc_dec, pc_plus4_dec, e[63:32], e[31:0], e[31:0] + 32'd4);
        end
        if (!pop_seen) begin
          pop_seen = 1'b1;
          first_pop_pc = pc_dec;
        end
      end
    end
    vectors++;
    if (dut.outst > MAX_OUTST || dut.discard > MAX_OUTST) begin
      miscompares++;
      $display("FAIL bounds @%0t: got outst %0d discard %0d want both <= %0d",
               $time, dut.outst, dut.discard, MAX_OUTST);
    end
    @(posedge cpu_clk);
    #1;
    if (rv && pend_q.size() > 0) void'(pend_q.pop_front());
    if (live && !consumed) exp_q.push_back({mem_word(rv_addr), rv_addr});
    if (hs) begin
      pend_q.push_back('{addr: hs_addr, tag: epoch});
      exp_fetch_pc = hs_addr + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_fetch_pc = rpc;
      m_mis = (rpc[1:0] != 2'b00);
    end
    if (resp_en && pend_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    pop_seen    = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rstn    = 1'b0;
    boot_addr   = 32'h100;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    dec_ready   = 1'b1;
    pop_seen    = 1'b0;
    exp_fetch_pc = 32'h100;
    repeat (2) @(posedge cpu_clk);
    #2;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    vectors++; if (pc_misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_misaligned: got %b want 0", pc_misaligned); end
    vectors++; if (fault_pc !== 32'h0) begin miscompares++; $display("FAIL rst_fault_pc: got %h want 0", fault_pc); end
    vectors++; if (instr_dec !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instr_dec); end
    vectors++; if (pc_dec !== 32'h100) begin miscompares++; $display("FAIL rst_pc_dec: got %h want 100", pc_dec); end
    vectors++; if (pc_plus4_dec !== 32'h104) begin miscompares++; $display("FAIL rst_pc_plus4: got %h want 104", pc_plus4_dec); end
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rst_imem_addr: got %h want 100", imem_addr); end
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_stream();
    steps(12);
    vectors++;
    if (!pop_seen || first_pop_pc !== 32'h100) begin
      miscompares++;
      $display("FAIL stream_first_pc: got %h (seen %b) want 100", first_pop_pc, pop_seen);
    end
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0;
    steps(10);
    #2;
    vectors++; if (dut.u_fifo.count !== 3'd4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", dut.u_fifo.count); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req: got %b want 0", imem_req); end
    dec_ready = 1'b1;
    steps(10);
  endtask

  task automatic test_redirect_outst();
    resp_en = 1'b0;
    for (int i = 0; i < 8 && pend_q.size() < 2; i++) step();
    vectors++;
    if (pend_q.size() != 2) begin
      miscompares++;
      $display("FAIL ro_setup: got %0d outstanding want 2", pend_q.size());
    end
    do_redirect(32'h2000);
    #2;
    vectors++; if (dut.discard !== 2'd2) begin miscompares++; $display("FAIL ro_discard: got %0d want 2", dut.discard); end
    resp_en = 1'b1;
    steps(12);
    vectors++;
    if (!pop_seen || first_pop_pc !== 32'h2000) begin
      miscompares++;
      $display("FAIL ro_first_pc: got %h (seen %b) want 2000", first_pop_pc, pop_seen);
    end
    vectors++; if (dut.discard !== 2'd0) begin miscompares++; $display("FAIL ro_discard_end: got %0d want 0", dut.discard); end
  endtask

  task automatic test_redirect_rvalid();
    for (int i = 0; i < 8 && !(imem_rvalid && pend_q.size() == 1); i++) step();
    vectors++;
    if (!(imem_rvalid && pend_q.size() == 1)) begin
      miscompares++;
      $display("FAIL rr_setup: got rvalid %b outstanding %0d want 1 and 1", imem_rvalid, pend_q.size());
    end
    do_redirect(32'h2400);
    #2;
    vectors++; if (dut.discard !== 2'd0) begin miscompares++; $display("FAIL rr_discard: got %0d want 0", dut.discard); end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2400) begin
      miscompares++;
      $display("FAIL rr_restart: got req %b addr %h want 1 2400", imem_req, imem_addr);
    end
    steps(10);
  endtask

  task automatic test_misaligned();
    do_redirect(32'h2002);
    #2;
    vectors++; if (pc_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b want 1", pc_misaligned); end
    vectors++; if (fault_pc !== 32'h2002) begin miscompares++; $display("FAIL mis_fault_pc: got %h want 2002", fault_pc); end
    steps(5);
    #2;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b want 0", imem_req); end
    vectors++; if (pc_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got %b want 1", pc_misaligned); end
    do_redirect(32'h3000);
    #2;
    vectors++; if (pc_misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", pc_misaligned); end
    vectors++; if (fault_pc !== 32'h0) begin miscompares++; $display("FAIL mis_fault_clear: got %h want 0", fault_pc); end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      miscompares++;
      $display("FAIL mis_resume: got req %b addr %h want 1 3000", imem_req, imem_addr);
    end
    steps(10);
    vectors++;
    if (!pop_seen || first_pop_pc !== 32'h3000) begin
      miscompares++;
      $display("FAIL mis_first_pc: got %h (seen %b) want 3000", first_pop_pc, pop_seen);
    end
  endtask

  task automatic test_halt();
    dec_ready = 1'b0;
    steps(3);
    halt = 1'b1;
    steps(4);
    #2;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_req: got %b want 0", imem_req); end
    vectors++;
    if (dut.u_fifo.count !== 3'(exp_q.size()) || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL halt_fill: got %0d entries want %0d (nonzero)", dut.u_fifo.count, exp_q.size());
    end
    dec_ready = 1'b1;
    steps(6);
    #2;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL halt_drain: got if_valid %b want 0", if_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_noreq: got %b want 0", imem_req); end
    halt = 1'b0;
    steps(8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      imem_gnt  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      resp_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) do_redirect(32'h4000 + 32'($urandom_range(0, 63)) * 4);
      else step();
    end
    imem_gnt  = 1'b1;
    dec_ready = 1'b1;
    resp_en   = 1'b1;
    steps(10);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outst();
    test_redirect_rvalid();
    test_misaligned();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
